// File: rtl/sr_input_conditioner.sv
// Push-button conditioner: per-channel 2-flop sync + debounce FSM, then
// registered set/reset pulses with simultaneous-accept suppression.

module sr_input_conditioner_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_sync1, r_sync2, r_level;
    logic          w_level_nx, w_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_level <= w_level_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rise     = 1'b0;
        case (r_state)
            LOW: begin
                if (r_sync2) begin
                    w_state_nx = CHK_HIGH;
                    w_cnt_nx   = CW'(1);
                end
            end
            CHK_HIGH: begin
                if (!r_sync2) begin
                    w_state_nx = LOW;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = HIGH;
                    w_rise     = 1'b1;
                end else if (r_cnt < CNT_LAST) begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            HIGH: begin
                if (!r_sync2) begin
                    w_state_nx = CHK_LOW;
                    w_cnt_nx   = CW'(1);
                end
            end
            CHK_LOW: begin
                if (r_sync2) begin
                    w_state_nx = HIGH;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = LOW;
                end else if (r_cnt < CNT_LAST) begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: w_state_nx = LOW;
        endcase
    end

    // Level tracks the state being entered so it moves on the same edge as the state.
    assign w_level_nx = (w_state_nx == HIGH) || (w_state_nx == CHK_LOW);
    assign o_level    = r_level;
    assign o_rise     = w_rise;
endmodule

module sr_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic s_level,
    output logic r_level,
    output logic conflict
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] w_btn, w_level, w_rise;

    assign w_btn = {btn_r, btn_s};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        sr_input_conditioner_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_btn  (w_btn[gi]),
            .o_level(w_level[gi]),
            .o_rise (w_rise[gi])
        );
    end

    // Coincident accepts cancel each other so the latch never sees s=r=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s        <= w_rise[0] & ~w_rise[1];
            r        <= w_rise[1] & ~w_rise[0];
            conflict <= w_rise[0] & w_rise[1];
        end
    end

    assign s_level = w_level[0];
    assign r_level = w_level[1];
endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed bench for sr_input_conditioner with DEBOUNCE_CYCLES=4.

module tb_sr_input_conditioner;
    logic clk = 1'b0;
    logic rst, btn_s, btn_r;
    logic s, r, s_level, r_level, conflict;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic seen_s, seen_r, seen_c;

    always #5 clk = ~clk;

    sr_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_s   (btn_s),
        .btn_r   (btn_r),
        .s       (s),
        .r       (r),
        .s_level (s_level),
        .r_level (r_level),
        .conflict(conflict)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample on the falling edge; checks s&r every cycle.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("s_and_r", {7'd0, s & r}, 8'd0);
            seen_s = seen_s | s;
            seen_r = seen_r | r;
            seen_c = seen_c | conflict;
        end
    endtask

    task automatic clr_seen();
        seen_s = 1'b0;
        seen_r = 1'b0;
        seen_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_s = 1'b0; btn_r = 1'b0;
        clr_seen();
        @(negedge clk);

        // Reset values
        step(3);
        chk("reset_outs", {3'd0, s, r, s_level, r_level, conflict}, 8'd0);
        rst = 1'b0;
        step(20);
        chk("idle_outs", {3'd0, s, r, s_level, r_level, conflict}, 8'd0);

        // Clean press on set channel
        clr_seen();
        btn_s = 1'b1;
        step(5);
        chk("press_e4", {6'd0, s, s_level}, 8'b00);
        step(1);
        chk("press_e5", {6'd0, s, s_level}, 8'b11);
        step(1);
        chk("press_e6", {6'd0, s, s_level}, 8'b01);
        step(13);
        chk("press_hold", {6'd0, s, s_level}, 8'b01);
        clr_seen();
        btn_s = 1'b0;
        step(5);
        chk("rel_e4", {7'd0, s_level}, 8'd1);
        step(1);
        chk("rel_e5", {7'd0, s_level}, 8'd0);
        step(3);
        chk("rel_no_pulse", {7'd0, seen_s}, 8'd0);

        // Bounce rejection on reset channel
        clr_seen();
        btn_r = 1'b1; step(1);
        btn_r = 1'b0; step(1);
        btn_r = 1'b1; step(1);
        step(1);
        btn_r = 1'b0; step(1);
        step(10);
        chk("bounce_pulse", {7'd0, seen_r}, 8'd0);
        chk("bounce_level", {7'd0, r_level}, 8'd0);
        btn_r = 1'b1;
        step(5);
        chk("r_press_e4", {6'd0, r, r_level}, 8'b00);
        step(1);
        chk("r_press_e5", {6'd0, r, r_level}, 8'b11);
        step(1);
        chk("r_press_e6", {6'd0, r, r_level}, 8'b01);
        btn_r = 1'b0;
        step(10);
        chk("r_released", {7'd0, r_level}, 8'd0);

        // Simultaneous press
        clr_seen();
        btn_s = 1'b1; btn_r = 1'b1;
        step(5);
        chk("sim_e4", {5'd0, conflict, s_level, r_level}, 8'b000);
        step(1);
        chk("sim_e5", {3'd0, conflict, s, r, s_level, r_level}, 8'b10011);
        step(1);
        chk("sim_e6", {5'd0, conflict, s_level, r_level}, 8'b011);
        step(5);
        chk("sim_no_pulse", {6'd0, seen_s, seen_r}, 8'd0);
        btn_s = 1'b0; btn_r = 1'b0;
        step(10);
        chk("sim_released", {6'd0, s_level, r_level}, 8'd0);

        // Staggered press: s at E0, r at E10
        clr_seen();
        btn_s = 1'b1;
        step(5);
        chk("stag_e4", {6'd0, s, r}, 8'b00);
        step(1);
        chk("stag_e5", {6'd0, s, r}, 8'b10);
        step(4);
        btn_r = 1'b1;
        step(5);
        chk("stag_e14", {6'd0, r, r_level}, 8'b00);
        step(1);
        chk("stag_e15", {5'd0, s, r, r_level}, 8'b011);
        step(1);
        chk("stag_e16", {6'd0, s, r}, 8'b00);
        chk("stag_no_conflict", {7'd0, seen_c}, 8'd0);
        btn_s = 1'b0; btn_r = 1'b0;
        step(10);
        chk("stag_released", {6'd0, s_level, r_level}, 8'd0);

        // Reset mid-debounce with button held
        clr_seen();
        btn_s = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_pulse", {6'd0, seen_s, s_level}, 8'd0);
        step(5);
        chk("rst_f4", {6'd0, s, s_level}, 8'b00);
        step(1);
        chk("rst_f5", {6'd0, s, s_level}, 8'b11);
        step(1);
        chk("rst_f6", {6'd0, s, s_level}, 8'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
